// File: rtl/stack_unit.sv
// LIFO data stack for the 8-bit CPU: push/pop with registered pop data and status.
// Optional sticky overflow/underflow flag enabled by defining STACK_UNIT_ERROR_EN.
module stack_unit #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           datain,
  output logic [WIDTH-1:0]           dataout,
  output logic                       popvalid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp, sp_next;
  logic [AW-1:0]    top, wr_addr;
  logic [WIDTH-1:0] dout_next, wr_data;
  logic             pv_next, wr_en;

  // sp == DEPTH truncates to 0, so top still lands on DEPTH-1 when full
  assign top   = sp[AW-1:0] - AW'(1);
  assign count = sp;

  always_comb begin
    sp_next   = sp;
    dout_next = dataout;
    pv_next   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = sp[AW-1:0];
    wr_data   = datain;
    case ({push, pop})
      2'b10: if (!full) begin
        wr_en   = 1'b1;
        sp_next = sp + CW'(1);
      end
      2'b01: if (!empty) begin
        dout_next = mem[top];
        pv_next   = 1'b1;
        sp_next   = sp - CW'(1);
      end
      2'b11: begin
        // simultaneous push/pop: replace top, or pass straight through when empty
        pv_next = 1'b1;
        if (empty) begin
          dout_next = datain;
        end else begin
          dout_next = mem[top];
          wr_en     = 1'b1;
          wr_addr   = top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp       <= '0;
      dataout  <= '0;
      popvalid <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      sp       <= sp_next;
      dataout  <= dout_next;
      popvalid <= pv_next;
      empty    <= (sp_next == '0);
      full     <= (sp_next == CW'(DEPTH));
    end
  end

  // storage is not cleared by reset
  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef STACK_UNIT_ERROR_EN
  logic err_evt;
  assign err_evt = (push & ~pop & full) | (pop & ~push & empty);

  always_ff @(posedge clock) begin
    if (reset)        error <= 1'b0;
    else if (err_evt) error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/stack_unit.md
# stack_unit

LIFO data stack for the 8-bit CPU, used for call/return and PUSH/POP instructions. It holds an internal stack pointer that moves up on push and down on pop, and owns the storage that pointer addresses. The control unit issues push/pop requests and reads popped data from a registered output one cycle later. Sits beside the register file on the CPU data bus.

## Interface
- DEPTH, 16, number of entries; power of two, 2..256
- WIDTH, 8, data word width
- clock  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-high reset; priority over all other inputs
- push  in  1  write datain onto top of stack this cycle
- pop  in  1  remove top entry; value appears on dataout next cycle
- datain  in  WIDTH  data to push
- dataout  out  WIDTH  last popped value, registered
- popvalid  out  1  one-cycle pulse: dataout updated by a pop this cycle
- count  out  $clog2(DEPTH+1)  current number of entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- error  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Pointer sp (= count) addresses next free slot; top entry at sp-1. No wrap-around: sp saturates in range 0..DEPTH.
- Cycle actions, evaluated on registered state at the rising edge:
  - reset: sp=0, dataout=0, popvalid=0, error=0. Storage contents not cleared (don't-care).
  - push only, not full: mem[sp]=datain, sp+1.
  - push only, full: overflow; no write, sp unchanged, error set.
  - pop only, not empty: dataout=mem[sp-1], popvalid=1, sp-1.
  - pop only, empty: underflow; dataout holds, popvalid=0, sp unchanged, error set.
  - push and pop, not empty (including full): replace top; dataout=old mem[sp-1], mem[sp-1]=datain, popvalid=1, sp unchanged. Not an error.
  - push and pop, empty: bypass; dataout=datain, popvalid=1, sp stays 0, storage untouched. Not an error.
  - neither: all state holds; popvalid=0.
- dataout holds its value until the next successful pop or reset.
- count, empty, full are decoded from registered sp; never combinational from push/pop.

## Timing
- All outputs registered; zero combinational paths from inputs to outputs.
- Pop latency: 1 cycle (request at edge N, dataout/popvalid valid after edge N).
- Push visible: count/full update after the same edge; pushed value poppable by a pop issued in the next cycle.
- Back-to-back push or pop every cycle supported, no bubbles.
- Reset mid-operation: a push/pop presented in a reset cycle is discarded; first usable request is the cycle after reset deasserts.
- Storage inferred as DEPTH x WIDTH register array; read uses sp-1 of current state.

## Configuration
- Macro STACK_UNIT_ERROR_EN.
- Defined: error sets on any overflow or underflow, stays 1 until reset.
- Undefined: error tied to 0, no sticky flag register; illegal operations are still ignored exactly as described (no state change).

## Test plan
- Reset then idle: count=0, empty=1, full=0, dataout=0, popvalid=0, error=0.
- Push 0x11, 0x22, 0x33, then pop x3 (DEPTH=16): dataout 0x33, 0x22, 0x11 on consecutive cycles, popvalid high 3 cycles, ends count=0, empty=1.
- Push 16 values 0x00..0x0F: full=1 after 16th; 17th push 0xAA ignored, error=1 (with macro); next pop returns 0x0F.
- Pop on empty: popvalid=0, dataout unchanged, count=0, error=1 with macro, error=0 without.
- With top=0x22, push 0x55 and pop same cycle: dataout=0x22, popvalid=1, count unchanged; next pop returns 0x55. On empty, push 0x77 and pop together: dataout=0x77, count=0.
- Push 0x44 in same cycle as reset high: after reset count=0, empty=1, error=0; subsequent pop is an underflow.
